// File: rtl/jtpang_rom_cslot.sv
// jtpang_rom_cslot
// SDRAM read slot with a two-entry cache for one bank request port.
// A client cs/addr request is turned into a 16-bit-word SDRAM read.
// The returned words are assembled into DW-bit client data.
// Repeated hits are answered from the cache without SDRAM traffic.
module jtpang_rom_cslot #(
    parameter int          DW     = 8,
    parameter int          AW     = 20,
    parameter logic [21:0] OFFSET = 22'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          slot_cs,
    input  logic [AW-1:0] slot_addr,
    output logic [DW-1:0] slot_dout,
    output logic          slot_ok,
    output logic          sdram_req,
    output logic [21:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_dst,
    input  logic          data_rdy,
    input  logic [15:0]   data_read
);

    // A 32-bit client needs two SDRAM words per line; narrower clients need one.
    localparam int LW = (DW == 32) ? 32 : 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ok_q, ok_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          req_q, req_d;
    logic [21:0]   addr_q, addr_d;
    logic          victim_q, victim_d;
    logic [15:0]   lo_q, lo_d;

    logic [1:0]    valid_q, valid_d;
    logic [21:0]   tag_q  [2];
    logic [21:0]   tag_d  [2];
    logic [LW-1:0] line_q [2];
    logic [LW-1:0] line_d [2];

    logic [21:0]   base_addr;
    logic [21:0]   word_addr;
    logic [1:0]    hit_vec;
    logic          hit;
    logic [LW-1:0] hit_line;
    logic [DW-1:0] hit_data;
    logic [15:0]   lo_now;
    logic [LW-1:0] fill_line;

    // Client address to SDRAM word address, depending on client width.
    generate
        if (DW == 8) begin : g_addr8
            assign base_addr = 22'(slot_addr >> 1);
        end else if (DW == 16) begin : g_addr16
            assign base_addr = 22'(slot_addr);
        end else begin : g_addr32
            assign base_addr = 22'({slot_addr, 1'b0});
        end
    endgenerate

    assign word_addr = base_addr + OFFSET;

    // Tag compare per entry. The two entries never share a tag, so at most one hits.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign hit_vec[gi] = valid_q[gi] && (tag_q[gi] == word_addr);
        end
    endgenerate

    assign hit      = |hit_vec;
    assign hit_line = hit_vec[1] ? line_q[1] : line_q[0];

    // Lane selection: bytes come from the low word, addr[0] picks the byte.
    generate
        if (DW == 8) begin : g_lane8
            assign hit_data = slot_addr[0] ? hit_line[15:8] : hit_line[7:0];
        end else begin : g_lane_wide
            assign hit_data = hit_line[DW-1:0];
        end
    endgenerate

    // The first word may arrive in the same cycle as data_rdy (single-word lines).
    assign lo_now = data_dst ? data_read : lo_q;

    generate
        if (LW == 32) begin : g_fill32
            assign fill_line = {data_read, lo_now};
        end else begin : g_fill16
            assign fill_line = lo_now;
        end
    endgenerate

    // Next-state logic: hit response, fetch FSM, cache fill and flush.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        victim_d = victim_q;
        lo_d     = lo_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        line_d   = line_q;

        // slot_ok always reflects the address presented on the previous clock.
        ok_d   = slot_cs && hit && !flush;
        dout_d = dout_q;
        if (ok_d) begin
            dout_d = hit_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (slot_cs && !hit && !flush) begin
                    addr_d  = word_addr;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Request stays up, address frozen, until the controller takes it.
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_dst) begin
                    lo_d = data_read;
                end
                if (data_rdy) begin
                    valid_d[victim_q] = 1'b1;
                    tag_d[victim_q]   = addr_q;
                    line_d[victim_q]  = fill_line;
                    victim_d          = ~victim_q;
                    state_d           = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush wins over everything: drop the cache and any fetch in flight.
        if (flush) begin
            valid_d = '0;
            ok_d    = 1'b0;
            req_d   = 1'b0;
            state_d = ST_IDLE;
        end
    end

    // State and cache registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ok_q     <= 1'b0;
            dout_q   <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            victim_q <= 1'b0;
            lo_q     <= '0;
            valid_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                tag_q[i]  <= '0;
                line_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ok_q     <= ok_d;
            dout_q   <= dout_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            lo_q     <= lo_d;
            valid_q  <= valid_d;
            for (int i = 0; i < 2; i++) begin
                tag_q[i]  <= tag_d[i];
                line_q[i] <= line_d[i];
            end
        end
    end

    assign slot_ok    = ok_q;
    assign slot_dout  = dout_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtpang_rom_cslot.sv
// Testbench for jtpang_rom_cslot: one DW=8 instance and one DW=32 instance.
// Expected client data is pushed into a scoreboard queue when a response is
// driven and popped when the slot raises slot_ok.
module tb_jtpang_rom_cslot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DW=8 instance
    logic        flush8;
    logic        cs8;
    logic [19:0] addr8;
    logic [7:0]  dout8;
    logic        ok8;
    logic        req8;
    logic [21:0] saddr8;
    logic        ack8;
    logic        dst8;
    logic        rdy8;
    logic [15:0] rd8;

    // DW=32 instance
    logic        flush32;
    logic        cs32;
    logic [19:0] addr32;
    logic [31:0] dout32;
    logic        ok32;
    logic        req32;
    logic [21:0] saddr32;
    logic        ack32;
    logic        dst32;
    logic        rdy32;
    logic [15:0] rd32;

    jtpang_rom_cslot #(.DW(8), .AW(20), .OFFSET(22'd0)) u8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush8),
        .slot_cs    (cs8),
        .slot_addr  (addr8),
        .slot_dout  (dout8),
        .slot_ok    (ok8),
        .sdram_req  (req8),
        .sdram_addr (saddr8),
        .sdram_ack  (ack8),
        .data_dst   (dst8),
        .data_rdy   (rdy8),
        .data_read  (rd8)
    );

    jtpang_rom_cslot #(.DW(32), .AW(20), .OFFSET(22'd0)) u32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush32),
        .slot_cs    (cs32),
        .slot_addr  (addr32),
        .slot_dout  (dout32),
        .slot_ok    (ok32),
        .sdram_req  (req32),
        .sdram_addr (saddr32),
        .sdram_ack  (ack32),
        .data_dst   (dst32),
        .data_rdy   (rdy32),
        .data_read  (rd32)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the DW=8 slot to raise sdram_req.
    task automatic wait_req8(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req8 && n < 20);
        check({tag, "_req"}, {31'd0, req8}, 32'd1);
    endtask

    // Wait (bounded) for slot_ok, then compare against the scoreboard head.
    task automatic wait_ok8(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ok8 && n < 20);
        check({tag, "_ok"}, {31'd0, ok8}, 32'd1);
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check({tag, "_dout"}, {24'd0, dout8}, e);
            $display("txn8 %s addr=0x%05h dout=0x%02h exp=0x%02h", tag, addr8, dout8, e[7:0]);
        end else begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
    endtask

    // Ack the pending request and return a single-word burst.
    task automatic complete8(input logic [15:0] d, input logic [7:0] exp, input string tag);
        ack8 = 1'b1;
        @(negedge clk);
        ack8 = 1'b0;
        check({tag, "_req_drop"}, {31'd0, req8}, 32'd0);
        dst8 = 1'b1;
        rdy8 = 1'b1;
        rd8  = d;
        exp_q.push_back({24'd0, exp});
        @(negedge clk);
        dst8 = 1'b0;
        rdy8 = 1'b0;
        rd8  = 16'h0000;
        wait_ok8(tag);
    endtask

    // Full miss: request, address check, response, data check.
    task automatic fetch8(input logic [19:0] a, input logic [15:0] d, input logic [7:0] exp,
                          input string tag);
        logic [21:0] wa;
        cs8   = 1'b1;
        addr8 = a;
        wa    = 22'(a) >> 1;
        wait_req8(tag);
        check({tag, "_saddr"}, {10'd0, saddr8}, {10'd0, wa});
        complete8(d, exp, tag);
    endtask

    // Hit: data must come back without any SDRAM request.
    task automatic hit8(input logic [19:0] a, input logic [7:0] exp, input string tag);
        cs8   = 1'b1;
        addr8 = a;
        exp_q.push_back({24'd0, exp});
        wait_ok8(tag);
        check({tag, "_noreq"}, {31'd0, req8}, 32'd0);
    endtask

    task automatic do_flush8(input string tag);
        cs8    = 1'b0;
        flush8 = 1'b1;
        @(negedge clk);
        check({tag, "_ok"}, {31'd0, ok8}, 32'd0);
        check({tag, "_req"}, {31'd0, req8}, 32'd0);
        flush8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stale;

        rst_n   = 1'b0;
        flush8  = 1'b0; cs8  = 1'b0; addr8  = '0; ack8  = 1'b0; dst8  = 1'b0; rdy8  = 1'b0; rd8  = '0;
        flush32 = 1'b0; cs32 = 1'b0; addr32 = '0; ack32 = 1'b0; dst32 = 1'b0; rdy32 = 1'b0; rd32 = '0;

        // Reset state
        #1;
        check("rst_ok8",    {31'd0, ok8},    32'd0);
        check("rst_dout8",  {24'd0, dout8},  32'd0);
        check("rst_req8",   {31'd0, req8},   32'd0);
        check("rst_saddr8", {10'd0, saddr8}, 32'd0);
        check("rst_ok32",   {31'd0, ok32},   32'd0);
        check("rst_req32",  {31'd0, req32},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // DW=32: two-word burst assembled as {second, first}
        cs32   = 1'b1;
        addr32 = 20'h00040;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req32 && n < 20);
        check("w32_req", {31'd0, req32}, 32'd1);
        check("w32_saddr", {10'd0, saddr32}, 32'h80);
        ack32 = 1'b1;
        @(negedge clk);
        ack32 = 1'b0;
        check("w32_req_drop", {31'd0, req32}, 32'd0);
        dst32 = 1'b1;
        rd32  = 16'h1234;
        @(negedge clk);
        dst32 = 1'b0;
        rdy32 = 1'b1;
        rd32  = 16'hABCD;
        exp_q.push_back(32'hABCD1234);
        @(negedge clk);
        rdy32 = 1'b0;
        rd32  = 16'h0000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ok32 && n < 20);
        check("w32_ok", {31'd0, ok32}, 32'd1);
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("w32_dout", dout32, e);
            $display("txn32 addr=0x%05h dout=0x%08h exp=0x%08h", addr32, dout32, e);
        end else begin
            check("w32_sb_empty", 32'd0, 32'd1);
        end
        cs32 = 1'b0;
        @(negedge clk);
        check("w32_ok_drop", {31'd0, ok32}, 32'd0);

        // DW=8: odd byte from a miss, then even byte from the cached word
        fetch8(20'h00011, 16'hA55A, 8'hA5, "b_odd");
        hit8(20'h00010, 8'h5A, "b_even_hit");

        // cs drop clears slot_ok after one clock
        cs8 = 1'b0;
        @(negedge clk);
        check("cs_drop_ok", {31'd0, ok8}, 32'd0);

        // Replacement: third miss evicts the oldest line
        do_flush8("fl_a");
        fetch8(20'h00010, 16'h1110, 8'h10, "ev_10");
        fetch8(20'h00020, 16'h2120, 8'h20, "ev_20");
        fetch8(20'h00030, 16'h3130, 8'h30, "ev_30");
        hit8(20'h00020, 8'h20, "ev_20_hit");
        fetch8(20'h00010, 16'h1110, 8'h10, "ev_10_again");

        // Address change while req is pending: fetch completes, then new request
        do_flush8("fl_b");
        cs8   = 1'b1;
        addr8 = 20'h00010;
        wait_req8("chg");
        check("chg_saddr0", {10'd0, saddr8}, 32'h08);
        addr8 = 20'h00020;
        @(negedge clk);
        @(negedge clk);
        check("chg_req_hold", {31'd0, req8}, 32'd1);
        check("chg_saddr_hold", {10'd0, saddr8}, 32'h08);
        ack8 = 1'b1;
        @(negedge clk);
        ack8 = 1'b0;
        dst8 = 1'b1;
        rdy8 = 1'b1;
        rd8  = 16'h1111;
        @(negedge clk);
        dst8 = 1'b0;
        rdy8 = 1'b0;
        rd8  = 16'h0000;
        stale = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (ok8) stale++;
            n++;
        end while (!req8 && n < 20);
        check("chg_req2", {31'd0, req8}, 32'd1);
        check("chg_stale_ok", stale, 32'd0);
        check("chg_saddr2", {10'd0, saddr8}, 32'h10);
        complete8(16'h2B22, 8'h22, "chg_fill");

        // Flush during WAIT: late data is discarded, same address refetches
        cs8   = 1'b1;
        addr8 = 20'h00040;
        wait_req8("flw");
        ack8 = 1'b1;
        @(negedge clk);
        ack8   = 1'b0;
        flush8 = 1'b1;
        @(negedge clk);
        flush8 = 1'b0;
        check("flw_req_off", {31'd0, req8}, 32'd0);
        dst8 = 1'b1;
        rdy8 = 1'b1;
        rd8  = 16'hDEAD;
        @(negedge clk);
        dst8 = 1'b0;
        rdy8 = 1'b0;
        rd8  = 16'h0000;
        check("flw_no_ok", {31'd0, ok8}, 32'd0);
        wait_req8("flw_reissue");
        check("flw_saddr", {10'd0, saddr8}, 32'h20);
        complete8(16'h7788, 8'h88, "flw_fill");

        // Async reset in the middle of WAIT
        cs8   = 1'b1;
        addr8 = 20'h00060;
        wait_req8("ar");
        ack8 = 1'b1;
        @(negedge clk);
        ack8 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ok",    {31'd0, ok8},    32'd0);
        check("ar_dout",  {24'd0, dout8},  32'd0);
        check("ar_req",   {31'd0, req8},   32'd0);
        check("ar_saddr", {10'd0, saddr8}, 32'd0);
        cs8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("ar_idle_req", {31'd0, req8}, 32'd0);
        fetch8(20'h00060, 16'h0F0E, 8'h0E, "ar_after");

        cs8 = 1'b0;
        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
